// File: rtl/cb_desegment_rx.sv
// Receive-side code-block desegmenter: drops filler bits, checks the attached CRC-24B and
// forwards payload bits. Every output is registered one cycle behind its input bit.
module cb_desegment_rx #(
  parameter int unsigned BLK_LONG  = 6144,
  parameter int unsigned BLK_SHORT = 1056,
  parameter int unsigned CRC_LEN   = 24,
  parameter logic [23:0] CRC_POLY  = 24'h800063
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_bit,
  input  logic in_start,
  input  logic in_size,
  input  logic in_has_crc,
  input  logic in_filling,
  input  logic in_crc,
  output logic out_valid,
  output logic out_bit,
  output logic out_sob,
  output logic out_eob,
  output logic blk_done,
  output logic blk_crc_ok,
  output logic blk_has_crc,
  output logic frm_err
);

  localparam logic [12:0] LenLongM1  = 13'(BLK_LONG - 1);
  localparam logic [12:0] LenShortM1 = 13'(BLK_SHORT - 1);
  localparam logic [12:0] CrcFirst   = 13'(CRC_LEN - 1);
  localparam logic [12:0] CrcLenW    = 13'(CRC_LEN);

  typedef enum logic [2:0] {StIdle, StFill, StData, StCrc, StDone} state_e;

  state_e      state_q, state_d, cur_st;
  logic [12:0] rem_q, rem_d, rem_cur, win, eob_rem;
  logic [23:0] crc_q, crc_d, crc_cur, crc_next;
  logic        has_crc_q, has_crc_d, has_cur;
  logic        sob_q, sob_d, sob_cur;
  logic        err_q, err_d, err_cur;
  logic        fb, shift_bit;
  logic        out_valid_q, out_valid_d, out_bit_q, out_bit_d;
  logic        out_sob_q, out_sob_d, out_eob_q, out_eob_d;
  logic        blk_done_q, blk_done_d, frm_err_q, frm_err_d;
  logic        blk_crc_ok_q, blk_crc_ok_d, blk_has_crc_q, blk_has_crc_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      rem_q         <= '0;
      crc_q         <= '0;
      has_crc_q     <= 1'b0;
      sob_q         <= 1'b0;
      err_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_bit_q     <= 1'b0;
      out_sob_q     <= 1'b0;
      out_eob_q     <= 1'b0;
      blk_done_q    <= 1'b0;
      frm_err_q     <= 1'b0;
      blk_crc_ok_q  <= 1'b0;
      blk_has_crc_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      crc_q         <= crc_d;
      has_crc_q     <= has_crc_d;
      sob_q         <= sob_d;
      err_q         <= err_d;
      out_valid_q   <= out_valid_d;
      out_bit_q     <= out_bit_d;
      out_sob_q     <= out_sob_d;
      out_eob_q     <= out_eob_d;
      blk_done_q    <= blk_done_d;
      frm_err_q     <= frm_err_d;
      blk_crc_ok_q  <= blk_crc_ok_d;
      blk_has_crc_q <= blk_has_crc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    crc_d         = crc_q;
    has_crc_d     = has_crc_q;
    sob_d         = sob_q;
    err_d         = err_q;
    out_valid_d   = 1'b0;
    out_bit_d     = 1'b0;
    out_sob_d     = 1'b0;
    out_eob_d     = 1'b0;
    blk_done_d    = 1'b0;
    frm_err_d     = 1'b0;
    blk_crc_ok_d  = blk_crc_ok_q;
    blk_has_crc_d = blk_has_crc_q;

    // A start bit replaces the held block context before the bit itself is processed.
    cur_st  = state_q;
    rem_cur = rem_q;
    crc_cur = crc_q;
    has_cur = has_crc_q;
    sob_cur = sob_q;
    err_cur = err_q;
    if (in_valid && in_start) begin
      cur_st  = in_filling ? StFill : StData;
      rem_cur = in_size ? LenLongM1 : LenShortM1;
      crc_cur = '0;
      has_cur = in_has_crc;
      sob_cur = 1'b1;
      err_cur = 1'b0;
    end

    shift_bit = in_bit & ~in_filling;
    fb        = crc_cur[23] ^ shift_bit;
    crc_next  = {crc_cur[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'h0);
    win       = has_cur ? CrcFirst : 13'd0;
    eob_rem   = has_cur ? CrcLenW : 13'd0;

    if (state_q == StDone) state_d = StIdle;

    if (in_valid) begin
      if (in_start && (state_q inside {StFill, StData, StCrc})) frm_err_d = 1'b1;

      if (cur_st == StIdle || cur_st == StDone) begin
        frm_err_d = 1'b1;
        state_d   = StIdle;
      end else begin
        rem_d     = rem_cur - 13'd1;
        crc_d     = crc_next;
        has_crc_d = has_cur;
        sob_d     = sob_cur;
        err_d     = err_cur;
        state_d   = cur_st;

        if (cur_st == StFill && in_filling) begin
          // Filler running into the CRC window (or the end) means there is no payload at all.
          if (rem_cur == win) begin
            frm_err_d = 1'b1;
            state_d   = StIdle;
          end
        end else if (in_filling) begin
          frm_err_d = 1'b1;
        end else if (cur_st == StCrc) begin
          if (!in_crc) begin
            frm_err_d = 1'b1;
            err_d     = 1'b1;
          end
        end else if (has_cur && rem_cur == CrcFirst) begin
          state_d = StCrc;
          if (!in_crc) begin
            frm_err_d = 1'b1;
            err_d     = 1'b1;
          end
        end else if (in_crc) begin
          state_d   = StData;
          frm_err_d = 1'b1;
          err_d     = 1'b1;
        end else begin
          state_d     = StData;
          out_valid_d = 1'b1;
          out_bit_d   = in_bit;
          out_sob_d   = sob_cur;
          out_eob_d   = (rem_cur == eob_rem);
          sob_d       = 1'b0;
        end

        if (rem_cur == 13'd0 && state_d != StIdle) begin
          state_d       = StDone;
          blk_done_d    = 1'b1;
          blk_crc_ok_d  = ~err_d & (~has_cur | (crc_next == 24'h0));
          blk_has_crc_d = has_cur;
        end
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_bit     = out_bit_q;
  assign out_sob     = out_sob_q;
  assign out_eob     = out_eob_q;
  assign blk_done    = blk_done_q;
  assign blk_crc_ok  = blk_crc_ok_q;
  assign blk_has_crc = blk_has_crc_q;
  assign frm_err     = frm_err_q;

endmodule

// File: doc/cb_desegment_rx.md
Name: cb_desegment_rx

Overview:
- Receive-side counterpart of the code-block segmentation data path.
- Consumes the serial per-block bit stream with its start/filling/crc side flags.
- Strips filler bits, checks the per-block CRC-24B when one is attached, and forwards only payload bits to the downstream reassembly FIFO.
- Reports a pass/fail status per block and flags framing violations.

Parameters:
- BLK_LONG, 6144, code-block length in bits when in_size=1
- BLK_SHORT, 1056, code-block length in bits when in_size=0
- CRC_LEN, 24, attached CRC length in bits
- CRC_POLY, 24'h800063, CRC-24B generator D^24+D^23+D^6+D^5+D+1, MSB-first

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  in_bit and flags valid this cycle; no backpressure
- in_bit  in  1  serial block bit
- in_start  in  1  marks the first bit of a block; qualified by in_valid
- in_size  in  1  block length select (1=BLK_LONG, 0=BLK_SHORT); sampled with in_start
- in_has_crc  in  1  block carries CRC-24B; sampled with in_start
- in_filling  in  1  current bit is a filler bit
- in_crc  in  1  current bit is a CRC bit
- out_valid  out  1  payload bit strobe; doubles as FIFO write request
- out_bit  out  1  payload bit
- out_sob  out  1  first payload bit of the block
- out_eob  out  1  last payload bit of the block
- blk_done  out  1  one-cycle pulse at block end
- blk_crc_ok  out  1  CRC result; held until the next blk_done
- blk_has_crc  out  1  copy of in_has_crc for the reported block; held
- frm_err  out  1  one-cycle pulse on a framing violation

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0 except blk_crc_ok=0 and blk_has_crc=0; counter and CRC register cleared. Assertion mid-block discards the block silently, with no blk_done and no frm_err.
- Cycles with in_valid=0 hold all state; out_valid, blk_done and frm_err are 0.
- Datapath is registered: outputs lag the corresponding input bit by exactly 1 cycle.
- Counter rem (13 bit) is loaded with len-1 on in_start, where len = in_size ? BLK_LONG : BLK_SHORT. It decrements on each valid bit. The block ends on the valid bit seen with rem=0.
- CRC register (24 bit): cleared on in_start, then shifted for every valid bit of the block. Filler bits are shifted in as 0 regardless of in_bit. Data and CRC bits are shifted as received.
- CRC result: blk_crc_ok=1 iff the register equals 0 after the final bit. When in_has_crc=0, blk_crc_ok is forced to 1.
- FSM states:
  - IDLE: in_valid&in_start -> FILL if in_filling, else DATA. A valid bit without in_start is dropped and pulses frm_err.
  - FILL: stays while in_filling=1; first non-filler bit -> DATA.
  - DATA: payload bits drive out_valid=1.
    - rem=CRC_LEN-1 with has_crc=1 must coincide with in_crc=1 -> CRC.
    - rem=0 with has_crc=0 -> DONE.
  - CRC: stays until rem=0 -> DONE. in_crc must be 1 on every bit here.
  - DONE: single internal cycle with no input consumption. blk_done=1, result registers update, then -> IDLE. in_start in the cycle immediately after the last bit is accepted: DONE overlaps and the next block starts without a bubble.
- out_sob marks the first bit emitted in DATA. out_eob marks the last DATA bit, i.e. the bit with rem=CRC_LEN if has_crc, else rem=0.
- Framing violations pulse frm_err for 1 cycle:
  - in_start outside IDLE/DONE: abort the current block with no blk_done, then restart on the new block using the new in_size/in_has_crc.
  - in_filling outside FILL: bit dropped; block continues.
  - in_crc in DATA before the CRC window, or in_crc=0 in CRC: block continues; blk_crc_ok is forced to 0.
  - A block consisting entirely of filler (rem reaches the CRC window or 0 while still in FILL): frm_err, -> IDLE.
- The payload count per block is len - fillers - (has_crc ? 24 : 0). No out_valid is ever produced for filler or CRC bits.

Test Plan:
- Short block, in_has_crc=0, 40 filler + 1016 random data bits -> exactly 1016 out_valid, out_sob on the 1st and out_eob on the 1016th; blk_done with blk_crc_ok=1, blk_has_crc=0.
- Long block, in_has_crc=1, 0 filler, 6120 data bits + correct CRC-24B -> 6120 out_valid; blk_crc_ok=1.
- Same long block with data bit 100 flipped -> 6120 out_valid; blk_crc_ok=0. Repeat with a correct payload but 40 fillers driven as in_bit=1 -> blk_crc_ok=1, since fillers are treated as 0.
- Two back-to-back short blocks with in_start on the cycle after the last bit -> two blk_done pulses and 2×(payload) out_valid; no frm_err.
- in_start asserted at data bit 500 of a long block -> frm_err pulse, no blk_done for the first block; the second block completes normally.
- reset driven low for 1 cycle at bit 3000 of a long block -> all outputs 0 immediately; no blk_done; the next in_start block is processed correctly.
